wam_engine: RTL and testbench

- Parametrised Whac-A-Mole game core: N-hole mole generator, tap/hit detection, BCD score and round timer in one single-clock block.
- Replaces derived/gated clocks with a one-cycle `tick` enable.
- Adds a round state machine (idle/play/pause/over) and countdown timer.
- Sits between the board I/O (debounced buttons, switches) and the LED / digital-tube display blocks.

---
 rtl/wam_if.sv | 25 ++
 rtl/wam_engine.sv | 195 +++++++++++++++++++
 tb/tb_wam_engine.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wam_if.sv
// Board-side bundle for wam_engine: controls and tap switches in, moles/hits/score/timer out.
// Plain level signals, no handshake: every field is sampled or updated once per clk.
interface wam_if #(
    parameter int N_HOLES      = 8,
    parameter int SCORE_DIGITS = 3,
    parameter int ROUND_TICKS  = 600
);
    localparam int TW = $clog2(ROUND_TICKS + 1);

    logic                      tick;
    logic                      start;
    logic                      pause;
    logic [3:0]                hrdn;
    logic [N_HOLES-1:0]        sw;
    logic [N_HOLES-1:0]        holes;
    logic [N_HOLES-1:0]        hit;
    logic [4*SCORE_DIGITS-1:0] score;
    logic [TW-1:0]             time_left;
    logic [1:0]                state;

    modport master (output tick, start, pause, hrdn, sw,
                    input  holes, hit, score, time_left, state);
    modport slave  (input  tick, start, pause, hrdn, sw,
                    output holes, hit, score, time_left, state);
endinterface

// File: rtl/wam_engine.sv
// Whac-A-Mole core: LFSR mole spawner, tap/hit detection, saturating BCD score, round timer; all outputs registered, one-clk update, no backpressure.
// Optional macro WAM_MISS_PENALTY_EN: taps on empty holes in PLAY subtract from the score (floored at 0).
module wam_engine #(
    parameter int          N_HOLES      = 8,
    parameter int          AGE_W        = 4,
    parameter int          SCORE_DIGITS = 3,
    parameter int          ROUND_TICKS  = 600,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic  clk,
    input logic  clr,
    wam_if.slave bus
);
    localparam int TW      = $clog2(ROUND_TICKS + 1);
    localparam int HW      = $clog2(N_HOLES);
    localparam int SW      = 4 * SCORE_DIGITS;
    localparam int AGE_MAX = (1 << AGE_W) - 1;
    localparam logic [SW-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

    state_t                        state_q, state_d;
    logic [N_HOLES-1:0]            holes_q, holes_d, hit_q, hit_d, sw_prev;
    logic [N_HOLES-1:0][AGE_W-1:0] age_q, age_d;
    logic [SW-1:0]                 score_q, score_d;
    logic [TW-1:0]                 time_q, time_d;
    logic [15:0]                   lfsr_q;

    logic [3:0]         hv;
    int                 life_i;
    logic [AGE_W-1:0]   life;
    logic [8:0]         spawn_thr;
    logic [HW-1:0]      cand;
    logic [N_HOLES-1:0] tap, spawn;
    logic               play, step, timeout, round_init;

    function automatic int popcnt(input logic [N_HOLES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_HOLES; i++) n += int'(v[i]);
        return n;
    endfunction

    // Digit-serial add of a small count; a carry out of the top digit pins the score at all-9s.
    function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] s, input int k);
        logic [SW-1:0] r;
        int c, v;
        r = s;
        c = k;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            v = int'(s[4*d +: 4]) + c;
            r[4*d +: 4] = 4'(v % 10);
            c = v / 10;
        end
        return (c != 0) ? SCORE_MAX : r;
    endfunction

    assign hv        = (bus.hrdn > 4'd9) ? 4'd9 : bus.hrdn;
    assign life_i    = AGE_MAX - int'(hv);
    assign life      = (life_i < 1) ? AGE_W'(1) : AGE_W'(life_i);
    assign spawn_thr = 9'd16 + {1'b0, hv, 4'b0000};
    assign cand      = HW'(lfsr_q[15:8] % 8'(N_HOLES));
    assign tap       = bus.sw ^ sw_prev;

    assign play       = (state_q == PLAY);
    assign step       = play && bus.tick;
    assign timeout    = step && (time_q == TW'(1));
    assign round_init = bus.start && (state_q == IDLE || state_q == OVER);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = PLAY;
            PLAY:    if (timeout) state_d = OVER;
                     else if (bus.pause) state_d = PAUSE;
            PAUSE:   if (bus.pause) state_d = PLAY;
            OVER:    if (bus.start) state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    // A tapped candidate never spawns, so a tap and a spawn cannot land on the same hole.
    always_comb begin
        spawn = '0;
        if (step && ({1'b0, lfsr_q[7:0]} < spawn_thr) && !holes_q[cand] && !tap[cand])
            spawn[cand] = 1'b1;
    end

    always_comb begin
        holes_d = holes_q;
        age_d   = age_q;
        hit_d   = '0;
        if (round_init) begin
            holes_d = '0;
            age_d   = '0;
        end else if (play) begin
            for (int i = 0; i < N_HOLES; i++) begin
                if (holes_q[i]) begin
                    if (tap[i]) begin
                        hit_d[i]   = 1'b1;
                        holes_d[i] = 1'b0;
                        age_d[i]   = '0;
                    end else if (bus.tick) begin
                        if (age_q[i] <= AGE_W'(1)) begin
                            holes_d[i] = 1'b0;
                            age_d[i]   = '0;
                        end else begin
                            age_d[i] = age_q[i] - AGE_W'(1);
                        end
                    end
                end else if (spawn[i]) begin
                    holes_d[i] = 1'b1;
                    age_d[i]   = life;
                end
            end
            if (timeout) begin
                holes_d = '0;
                age_d   = '0;
            end
        end
    end

`ifdef WAM_MISS_PENALTY_EN
    logic [N_HOLES-1:0] miss;
    int                 net;

    function automatic logic [SW-1:0] bcd_sub(input logic [SW-1:0] s, input int k);
        logic [SW-1:0] r;
        int b, v;
        r = s;
        b = k;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            v = int'(s[4*d +: 4]) - b;
            if (v < 0) begin
                b = (9 - v) / 10;
                v = v + 10 * b;
            end else begin
                b = 0;
            end
            r[4*d +: 4] = 4'(v);
        end
        return (b != 0) ? '0 : r;
    endfunction

    assign miss = play ? (tap & ~holes_q) : '0;
    assign net  = popcnt(hit_d) - popcnt(miss);

    always_comb begin
        score_d = score_q;
        if (round_init)   score_d = '0;
        else if (net > 0) score_d = bcd_add(score_q, net);
        else if (net < 0) score_d = bcd_sub(score_q, -net);
    end
`else
    always_comb begin
        score_d = score_q;
        if (round_init) score_d = '0;
        else            score_d = bcd_add(score_q, popcnt(hit_d));
    end
`endif

    always_comb begin
        time_d = time_q;
        if (round_init) time_d = TW'(ROUND_TICKS);
        else if (step)  time_d = time_q - TW'(1);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            holes_q <= '0;
            hit_q   <= '0;
            age_q   <= '0;
            score_q <= '0;
            time_q  <= TW'(ROUND_TICKS);
            sw_prev <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            holes_q <= holes_d;
            hit_q   <= hit_d;
            age_q   <= age_d;
            score_q <= score_d;
            time_q  <= time_d;
            sw_prev <= bus.sw;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign bus.holes     = holes_q;
    assign bus.hit       = hit_q;
    assign bus.score     = score_q;
    assign bus.time_left = time_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_wam_engine.sv
// Directed bench for wam_engine: a spawn-LFSR model picks tick cycles so hole contents stay known.
// A second instance with a long round drives the score up to the saturation boundary.
module tb_wam_engine;
    logic clk = 1'b0;
    logic clr;

    wam_if #(.N_HOLES(8), .SCORE_DIGITS(3), .ROUND_TICKS(600))  bus ();
    wam_if #(.N_HOLES(8), .SCORE_DIGITS(3), .ROUND_TICKS(4000)) bus2 ();

    wam_engine #(.N_HOLES(8), .AGE_W(4), .SCORE_DIGITS(3), .ROUND_TICKS(600), .LFSR_SEED(16'hACE1))
        dut (.clk(clk), .clr(clr), .bus(bus));
    wam_engine #(.N_HOLES(8), .AGE_W(4), .SCORE_DIGITS(3), .ROUND_TICKS(4000), .LFSR_SEED(16'hACE1))
        dut2 (.clk(clk), .clr(clr), .bus(bus2));

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_lfsr;
    int          exp_time, exp_score, exp2, h, h2, n;
    logic [7:0]  exp_holes, t;

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] lowest(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic int ones(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!clr) m_lfsr = nxt(m_lfsr);
        #1;
    endtask

    // Wait for a cycle whose LFSR value spawns into an empty hole (optionally a specific one), tick there.
    task automatic find_spawn(input int hv, input logic [7:0] occ, input int want, output int hole);
        int c;
        hole = -1;
        for (int k = 0; k < 4000 && hole < 0; k++) begin
            c = int'(m_lfsr[15:8]) % 8;
            if (int'(m_lfsr[7:0]) < 16 + 16 * hv && !occ[c] && (want < 0 || c == want)) begin
                bus.tick = 1'b1;
                hole = c;
            end
            step();
            bus.tick = 1'b0;
        end
        if (hole < 0) check("spawn_search_timeout", 0, 1);
    endtask

    // Tick on a cycle that cannot spawn, optionally with taps on the same edge.
    task automatic tick_quiet(input int hv, input logic [7:0] taps);
        int k;
        k = 0;
        while (int'(m_lfsr[7:0]) < 16 + 16 * hv && k < 4000) begin
            step();
            k++;
        end
        if (k >= 4000) check("quiet_search_timeout", 0, 1);
        bus.tick = 1'b1;
        bus.sw   = bus.sw ^ taps;
        step();
        bus.tick = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick = 0;  bus.start = 0;  bus.pause = 0;  bus.hrdn = 0;  bus.sw = 0;
        bus2.tick = 0; bus2.start = 0; bus2.pause = 0; bus2.hrdn = 9; bus2.sw = 0;
        clr    = 1'b1;
        m_lfsr = 16'hACE1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        check("rst_state", bus.state, 0);
        check("rst_time", bus.time_left, 600);
        check("rst_score", bus.score, 0);
        check("rst_holes", bus.holes, 0);
        check("rst_hit", bus.hit, 0);

        bus.tick = 1; bus.sw = 8'h0F; step(); bus.tick = 0;
        check("idle_tick_time", bus.time_left, 600);
        check("idle_tap_score", bus.score, 0);

        bus.start = 1; step(); bus.start = 0;
        check("start_state", bus.state, 1);
        exp_time = 600; exp_score = 0;

        find_spawn(0, 8'h00, 3, h); exp_time--;
        check("spawn3_holes", bus.holes, 8'h08);
        check("spawn3_time", bus.time_left, exp_time);
        repeat (3) begin tick_quiet(0, 8'h00); exp_time--; end
        check("age3_holes", bus.holes, 8'h08);
        check("age3_time", bus.time_left, exp_time);

        bus.sw[3] = ~bus.sw[3]; step(); exp_score++;
        check("hit3_pulse", bus.hit, 8'h08);
        check("hit3_holes", bus.holes, 8'h00);
        check("hit3_score", bus.score, to_bcd(exp_score));
        step();
        check("hit3_pulse_end", bus.hit, 8'h00);

        bus.sw = bus.sw ^ 8'h07; step();
`ifdef WAM_MISS_PENALTY_EN
        exp_score = 0;
`endif
        check("miss_score", bus.score, to_bcd(exp_score));
        check("miss_hit", bus.hit, 8'h00);

        find_spawn(0, 8'h00, -1, h); exp_time--;
        exp_holes = 8'(1 << h);
        check("pause_pre_holes", bus.holes, exp_holes);
        bus.pause = 1; step(); bus.pause = 0;
        check("pause_state", bus.state, 2);
        bus.tick = 1;
        repeat (50) begin bus.sw = bus.sw ^ 8'hFF; step(); end
        bus.tick = 0;
        check("pause_state_hold", bus.state, 2);
        check("pause_time", bus.time_left, exp_time);
        check("pause_holes", bus.holes, exp_holes);
        check("pause_score", bus.score, to_bcd(exp_score));
        check("pause_hit", bus.hit, 8'h00);
        bus.pause = 1; step(); bus.pause = 0;
        check("resume_state", bus.state, 1);
        tick_quiet(0, 8'h00); exp_time--;
        check("resume_time", bus.time_left, exp_time);
        tick_quiet(0, exp_holes); exp_time--; exp_score++;
        check("resume_hit", bus.hit, exp_holes);
        check("resume_score", bus.score, to_bcd(exp_score));
        check("resume_holes", bus.holes, 8'h00);

        bus.hrdn = 4'd15;
        find_spawn(9, 8'h00, -1, h); exp_time--;
        exp_holes = 8'(1 << h);
        repeat (5) begin tick_quiet(9, 8'h00); exp_time--; end
        check("exp_hold_5", bus.holes, exp_holes);
        tick_quiet(9, 8'h00); exp_time--;
        check("exp_clear_6", bus.holes, 8'h00);
        check("exp_score", bus.score, to_bcd(exp_score));
        check("exp_time", bus.time_left, exp_time);

        find_spawn(9, 8'h00, -1, h2); exp_time--;
        exp_holes = 8'(1 << h2);
        repeat (5) begin tick_quiet(9, 8'h00); exp_time--; end
        tick_quiet(9, exp_holes); exp_time--; exp_score++;
        check("hit_vs_expiry_hit", bus.hit, exp_holes);
        check("hit_vs_expiry_score", bus.score, to_bcd(exp_score));

        bus.tick = 1;
        repeat (exp_time - 1) step();
        check("runout_last_time", bus.time_left, 1);
        check("runout_last_state", bus.state, 1);
        step();
        check("over_state", bus.state, 3);
        check("over_time", bus.time_left, 0);
        check("over_holes", bus.holes, 8'h00);
        check("over_score", bus.score, to_bcd(exp_score));
        bus.sw = bus.sw ^ 8'hFF; step(); bus.tick = 0;
        check("over_idle_state", bus.state, 3);
        check("over_idle_time", bus.time_left, 0);
        check("over_tap_score", bus.score, to_bcd(exp_score));

        bus.start = 1; bus.pause = 1; step();
        check("restart_state", bus.state, 1);
        check("restart_score", bus.score, 0);
        check("restart_time", bus.time_left, 600);
        step(); bus.start = 0;
        check("start_ignored_pause", bus.state, 2);
        step(); bus.pause = 0;
        check("unpause_state", bus.state, 1);

        bus.tick = 1;
        repeat (599) step();
        check("round_599_state", bus.state, 1);
        check("round_599_time", bus.time_left, 1);
        step(); bus.tick = 0;
        check("round_600_state", bus.state, 3);
        check("round_600_time", bus.time_left, 0);
        check("round_600_holes", bus.holes, 8'h00);
        check("round_600_score", bus.score, 0);

        bus.start = 1; step(); bus.start = 0;
        find_spawn(9, 8'h00, -1, h);
        bus.sw = bus.sw ^ 8'(1 << h); step();
        check("pre_rst_score", bus.score, to_bcd(1));
        find_spawn(9, 8'h00, -1, h);
        clr = 1'b1; m_lfsr = 16'hACE1;
        #1;
        check("midrst_state", bus.state, 0);
        check("midrst_time", bus.time_left, 600);
        check("midrst_score", bus.score, 0);
        check("midrst_holes", bus.holes, 8'h00);
        @(posedge clk); #1 clr = 1'b0;

        bus2.start = 1; step(); bus2.start = 0;
        exp2 = 0; n = 0;
        bus2.tick = 1;
        while (exp2 < 998 && n < 3500) begin
            t = lowest(bus2.holes);
            bus2.sw = bus2.sw ^ t;
            if (t != 8'h00) exp2++;
            step();
            n++;
        end
        check("sat_pre_score", bus2.score, to_bcd(998));
        bus2.hrdn = 5; n = 0;
        while (ones(bus2.holes) < 3 && n < 400) begin step(); n++; end
        bus2.tick = 0;
        t = bus2.holes;
        check("sat_three_ready", 32'(ones(t) >= 3), 1);
        bus2.sw = bus2.sw ^ t; step();
        check("sat_multi_hit", bus2.hit, t);
        check("sat_score", bus2.score, 12'h999);
        bus2.tick = 1; n = 0;
        while (bus2.holes == 8'h00 && n < 400) begin step(); n++; end
        bus2.tick = 0;
        t = lowest(bus2.holes);
        bus2.sw = bus2.sw ^ t; step();
        check("sat_extra_hit", bus2.hit, t);
        check("sat_hold", bus2.score, 12'h999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
